// File: rtl/stream_echoer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | stream_echoer_if                                                      |
// | Valid/ready symbol stream used for both directions of stream_echoer.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface stream_echoer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface
`default_nettype wire

// File: rtl/stream_echoer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | stream_echoer                                                         |
// | FIFO echo with per-push transform, EOL-gated line mode and counters.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module stream_echoer #(
  parameter int              WIDTH = 8,
  parameter int              DEPTH = 8,
  parameter logic [WIDTH-1:0] EOL  = WIDTH'(8'h0A),
  parameter int              CNT_W = 16
) (
  input  wire                     clk,
  input  wire                     rst,
  input  wire [1:0]               mode,
  input  wire [WIDTH-1:0]         xor_mask,
  stream_echoer_if.slave          host_to_dev,
  stream_echoer_if.master         dev_to_host,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic [$clog2(DEPTH):0]  n_lines,
  output logic [CNT_W-1:0]        n_symbols
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_XOR  = 2'd1;
  localparam logic [1:0] MODE_INC  = 2'd2;
  localparam logic [1:0] MODE_LINE = 2'd3;

  localparam logic [AW:0]      LVL_FULL = DEPTH[AW:0];
  localparam logic [AW:0]      LVL_ZERO = '0;
  localparam logic [AW:0]      LVL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0]    PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DATA_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem_data [DEPTH];
  logic             r_mem_tag  [DEPTH];

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [AW:0]      r_n_lines;
  logic             r_flush;
  logic [CNT_W-1:0] r_n_symbols;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;
  logic             w_in_tag;
  logic             w_head_tag;
  logic [WIDTH-1:0] w_xform;

  assign w_in_ready  = (r_count < LVL_FULL) && !rst;
  assign w_push      = host_to_dev.valid && w_in_ready;
  assign w_pop       = w_out_valid && dev_to_host.ready;
  assign w_in_tag    = (host_to_dev.data == EOL);
  assign w_head_tag  = r_mem_tag[r_rd_ptr];

  // Line mode holds output back until a whole line is stored, unless the
  // FIFO filled up without one, in which case it drains until empty.
  always_comb begin
    w_out_valid = (r_count != LVL_ZERO);
    if (mode == MODE_LINE)
      w_out_valid = (r_count != LVL_ZERO) && ((r_n_lines != LVL_ZERO) || r_flush);
  end

  always_comb begin
    w_xform = host_to_dev.data;
    case (mode)
      MODE_PASS: w_xform = host_to_dev.data;
      MODE_XOR,
      MODE_LINE: w_xform = host_to_dev.data ^ xor_mask;
      MODE_INC:  w_xform = host_to_dev.data + DATA_ONE;
      default:   w_xform = host_to_dev.data;
    endcase
  end

  // Storage is not reset; entries are meaningless once the pointers clear.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_xform;
      r_mem_tag[r_wr_ptr]  <= w_in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_n_lines   <= '0;
      r_flush     <= 1'b0;
      r_n_symbols <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PTR_ONE;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LVL_ONE;
        2'b01:   r_count <= r_count - LVL_ONE;
        default: r_count <= r_count;
      endcase

      case ({w_push && w_in_tag, w_pop && w_head_tag})
        2'b10:   r_n_lines <= r_n_lines + LVL_ONE;
        2'b01:   r_n_lines <= r_n_lines - LVL_ONE;
        default: r_n_lines <= r_n_lines;
      endcase

      // Follows the registered level, so it lags full/empty by one cycle.
      if (r_count == LVL_FULL)
        r_flush <= 1'b1;
      else if (r_count == LVL_ZERO)
        r_flush <= 1'b0;

      if (w_push && (r_n_symbols != {CNT_W{1'b1}}))
        r_n_symbols <= r_n_symbols + CNT_ONE;
    end
  end

  assign host_to_dev.ready = w_in_ready;
  assign dev_to_host.valid = w_out_valid;
  assign dev_to_host.data  = w_out_valid ? r_mem_data[r_rd_ptr] : '0;
  assign occupancy         = r_count;
  assign n_lines           = r_n_lines;
  assign n_symbols         = r_n_symbols;

endmodule
`default_nettype wire

// File: tb/tb_stream_echoer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_stream_echoer                                                      |
// | Directed self-checking bench for stream_echoer (CNT_W=4 for saturation).|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_stream_echoer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [7:0] xor_mask;
  logic [3:0] occupancy;
  logic [3:0] n_lines;
  logic [3:0] n_symbols;

  int tests = 0;
  int fails = 0;

  stream_echoer_if #(.WIDTH(8)) h2d ();
  stream_echoer_if #(.WIDTH(8)) d2h ();

  stream_echoer #(
    .WIDTH (8),
    .DEPTH (8),
    .EOL   (8'h0A),
    .CNT_W (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .xor_mask    (xor_mask),
    .host_to_dev (h2d.slave),
    .dev_to_host (d2h.master),
    .occupancy   (occupancy),
    .n_lines     (n_lines),
    .n_symbols   (n_symbols)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    mode      = 2'd0;
    xor_mask  = 8'h00;
    h2d.data  = 8'h00;
    h2d.valid = 1'b0;
    d2h.ready = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_ready",   32'(h2d.ready), 32'h0);
    check("rst_occ",     32'(occupancy), 32'h0);
    check("rst_valid",   32'(d2h.valid), 32'h0);
    check("rst_data",    32'(d2h.data),  32'h0);
    check("rst_nsym",    32'(n_symbols), 32'h0);
    check("rst_nlines",  32'(n_lines),   32'h0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(h2d.ready), 32'h1);

    // XOR mode, 'a','b' back to back
    mode = 2'd1; xor_mask = 8'h20; d2h.ready = 1'b1;
    h2d.valid = 1'b1; h2d.data = 8'h61;
    #1;
    check("xor_no_comb_path", 32'(d2h.valid), 32'h0);
    tick();
    h2d.data = 8'h62;
    #1;
    check("xor_A_valid", 32'(d2h.valid), 32'h1);
    check("xor_A_data",  32'(d2h.data),  32'h41);
    tick();
    h2d.valid = 1'b0;
    #1;
    check("xor_B_data",  32'(d2h.data),  32'h42);
    check("xor_B_occ",   32'(occupancy), 32'h1);
    tick();
    check("xor_empty_valid", 32'(d2h.valid), 32'h0);
    check("xor_empty_data",  32'(d2h.data),  32'h0);
    check("xor_nsym",        32'(n_symbols), 32'h2);

    // Pass mode, fill with output stalled, then drain across pointer wrap
    mode = 2'd0; d2h.ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      h2d.valid = 1'b1;
      h2d.data  = 8'h10 + 8'(i);
      #1;
      check($sformatf("fill_ready_%0d", i), 32'(h2d.ready), (i < 8) ? 32'h1 : 32'h0);
      tick();
    end
    h2d.valid = 1'b0;
    #1;
    check("full_occ",   32'(occupancy), 32'h8);
    check("full_ready", 32'(h2d.ready), 32'h0);
    d2h.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("drain_data_%0d", i), 32'(d2h.data), 32'h10 + 32'(i));
      tick();
    end
    check("drain_valid", 32'(d2h.valid), 32'h0);
    check("drain_occ",   32'(occupancy), 32'h0);
    tick();

    // Line mode: "hi\n"
    mode = 2'd3; xor_mask = 8'h00; d2h.ready = 1'b1;
    h2d.valid = 1'b1; h2d.data = 8'h68;
    tick();
    check("line_h_hold", 32'(d2h.valid), 32'h0);
    h2d.data = 8'h69;
    tick();
    check("line_i_hold", 32'(d2h.valid), 32'h0);
    check("line_i_occ",  32'(occupancy), 32'h2);
    h2d.data = 8'h0A;
    tick();
    h2d.valid = 1'b0;
    #1;
    check("line_nlines", 32'(n_lines),   32'h1);
    check("line_valid",  32'(d2h.valid), 32'h1);
    check("line_d0",     32'(d2h.data),  32'h68);
    tick();
    check("line_d1",     32'(d2h.data),  32'h69);
    tick();
    check("line_d2",     32'(d2h.data),  32'h0A);
    check("line_d2_nl",  32'(n_lines),   32'h1);
    tick();
    check("line_done_valid", 32'(d2h.valid), 32'h0);
    check("line_done_nl",    32'(n_lines),   32'h0);

    // Line mode overflow flush
    for (int i = 0; i < 8; i++) begin
      h2d.valid = 1'b1;
      h2d.data  = 8'h30 + 8'(i);
      #1;
      check($sformatf("ovf_hold_%0d", i), 32'(d2h.valid), 32'h0);
      tick();
    end
    h2d.valid = 1'b0;
    #1;
    check("ovf_full_valid", 32'(d2h.valid), 32'h0);
    check("ovf_full_ready", 32'(h2d.ready), 32'h0);
    tick();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovf_drain_%0d", i), 32'(d2h.data), 32'h30 + 32'(i));
      tick();
    end
    check("ovf_empty_valid", 32'(d2h.valid), 32'h0);
    check("nsym_saturated",  32'(n_symbols), 32'hF);
    tick();

    // Increment mode, stable head, mode change, reset mid-stream
    mode = 2'd2; d2h.ready = 1'b1;
    h2d.valid = 1'b1; h2d.data = 8'hFF;
    tick();
    d2h.ready = 1'b0;
    h2d.data  = 8'hAA;
    #1;
    check("inc_wrap_data", 32'(d2h.data), 32'h00);
    tick();
    h2d.data = 8'hBB;
    tick();
    h2d.valid = 1'b0;
    #1;
    check("inc_occ",         32'(occupancy), 32'h3);
    check("inc_head_stable", 32'(d2h.data),  32'h00);
    check("inc_head_valid",  32'(d2h.valid), 32'h1);
    mode = 2'd0;
    #1;
    check("mode_chg_data",   32'(d2h.data),  32'h00);
    mode = 2'd3;
    #1;
    check("mode3_gate_valid", 32'(d2h.valid), 32'h0);
    check("mode3_gate_data",  32'(d2h.data),  32'h0);
    mode = 2'd2;
    rst = 1'b1; h2d.valid = 1'b1; h2d.data = 8'h05; d2h.ready = 1'b1;
    #1;
    check("rst_comb_ready", 32'(h2d.ready), 32'h0);
    tick();
    check("mid_rst_occ",   32'(occupancy), 32'h0);
    check("mid_rst_valid", 32'(d2h.valid), 32'h0);
    check("mid_rst_ready", 32'(h2d.ready), 32'h0);
    check("mid_rst_nsym",  32'(n_symbols), 32'h0);
    rst = 1'b0; h2d.valid = 1'b0;
    tick();
    check("post_rst_occ",  32'(occupancy), 32'h0);

    // EOL tag follows raw input even when transformed
    mode = 2'd1; xor_mask = 8'h20; d2h.ready = 1'b0;
    h2d.valid = 1'b1; h2d.data = 8'h0A;
    tick();
    h2d.valid = 1'b0;
    #1;
    check("tag_nlines", 32'(n_lines),   32'h1);
    check("tag_data",   32'(d2h.data),  32'h2A);
    check("tag_nsym",   32'(n_symbols), 32'h1);
    mode = 2'd3;
    #1;
    check("tag_mode3_valid", 32'(d2h.valid), 32'h1);
    d2h.ready = 1'b1;
    tick();
    check("tag_pop_occ",    32'(occupancy), 32'h0);
    check("tag_pop_nlines", 32'(n_lines),   32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_echoer.md
STREAM_ECHOER -- requirements
Module: streamEchoer

Interface
REQ-001 Parameter WIDTH, default 8, symbol width in bits (>=1).
REQ-002 Parameter DEPTH, default 8, FIFO entries (power of 2, >=2).
REQ-003 Parameter EOL, default 8'h0A (WIDTH bits), line terminator for line mode.
REQ-004 Parameter CNT_W, default 16, width of the statistics counter.
REQ-005 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-006 i_rst  in  1  reset, synchronous, active-high.
REQ-007 i_mode  in  2  0=pass, 1=XOR, 2=increment, 3=line-buffered XOR.
REQ-008 i_xorMask  in  WIDTH  mask applied in modes 1 and 3.
REQ-009 i_hostToDev_data  in  WIDTH  incoming symbol.
REQ-010 i_hostToDev_valid  in  1  incoming symbol valid.
REQ-011 o_hostToDev_ready  out  1  block can accept a symbol.
REQ-012 o_devToHost_data  out  WIDTH  echoed symbol.
REQ-013 o_devToHost_valid  out  1  echoed symbol valid.
REQ-014 i_devToHost_ready  in  1  downstream accepts symbol.
REQ-015 o_occupancy  out  $clog2(DEPTH)+1  stored entries.
REQ-016 o_nLines  out  $clog2(DEPTH)+1  stored EOL-tagged entries.
REQ-017 o_nSymbols  out  CNT_W  saturating count of accepted input symbols.

Function
REQ-018 Push occurs when i_hostToDev_valid && o_hostToDev_ready; pop occurs when o_devToHost_valid && i_devToHost_ready.
REQ-019 o_hostToDev_ready SHALL be 1 exactly when occupancy < DEPTH and i_rst is low.
REQ-020 Transform SHALL be applied at push using the i_mode and i_xorMask values of that cycle: mode 0 unchanged, modes 1/3 data^mask, mode 2 (data+1) mod 2^WIDTH.
REQ-021 Each entry SHALL carry a tag bit, set when the raw (untransformed) input equals EOL, regardless of mode.
REQ-022 Storage SHALL be a circular FIFO; read/write pointers wrap from DEPTH-1 to 0.
REQ-023 Minimum latency SHALL be 1 cycle: a symbol pushed in cycle N may be valid on the output no earlier than cycle N+1; no combinational input-to-output path.
REQ-024 In modes 0-2, o_devToHost_valid SHALL equal (occupancy != 0).
REQ-025 In mode 3, o_devToHost_valid SHALL equal (occupancy != 0) && (nLines != 0 || overflowFlush).
REQ-026 overflowFlush SHALL set in the cycle after occupancy reaches DEPTH and clear in the cycle after occupancy reaches 0.
REQ-027 nLines SHALL increment on a push of a tagged entry, decrement on a pop of a tagged entry, and stay unchanged when both occur in the same cycle.
REQ-028 Simultaneous push and pop SHALL leave occupancy unchanged; push when full and pop when empty SHALL never occur.
REQ-029 o_devToHost_data SHALL present the head entry when valid, and 0 otherwise.
REQ-030 Once asserted, o_devToHost_valid SHALL stay high with stable data until popped, unless i_mode changes to 3 or i_rst asserts.
REQ-031 Changing i_mode with data stored SHALL NOT alter stored entries; only gating (REQ-024/025) follows the new mode.
REQ-032 o_nSymbols SHALL increment on every push and saturate at 2^CNT_W-1.

Reset
REQ-033 In the cycle after i_rst is sampled high: pointers, occupancy, nLines, overflowFlush and o_nSymbols = 0; o_devToHost_valid = 0; o_devToHost_data = 0.
REQ-034 A push or pop coincident with i_rst SHALL be discarded, including during mid-stream operation.
REQ-035 Stored data SHALL be considered lost after reset; memory contents need not be cleared.

Verification
REQ-036 Mode 1, mask 8'h20, push 'a','b' back to back with ready=1 -> 'A' valid at cycle N+1, 'B' at N+2; o_nSymbols=2.
REQ-037 Mode 0, hold i_devToHost_ready=0, push 9 symbols -> ready drops after 8th, occupancy=8; release ready -> symbols emerge in order and pointers wrap.
REQ-038 Mode 3, mask 0, push "hi" then 8'h0A -> valid stays 0 until the EOL is stored, then 3 symbols pop and nLines returns 0.
REQ-039 Mode 3, push 8 non-EOL symbols -> overflowFlush asserts, all 8 drain, valid deasserts at empty.
REQ-040 Mode 2, push 8'hFF -> output 8'h00; assert i_rst with 3 entries stored -> next cycle occupancy=0, valid=0, ready=0.
